// File: rtl/pin_capture_pkg.sv
// pin_capture_pkg: shared wishbone register map, STATUS/ARM bit positions and pin priority helper
package pin_capture_pkg;
  localparam logic [3:0] ADDR_FILTER = 4'd0;
  localparam logic [3:0] ADDR_ARM = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_TTIME = 4'd3;
  localparam logic [3:0] ADDR_STATE = 4'd4;
  localparam int STATUS_TRIG_BIT = 31;
  localparam int ARM_LEVEL_LSB = 8;
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/pin_capture_filter.sv
// pin_filter: one pin's 2-flop sync + debounce (clk, rst async low, pin, filter threshold -> stable)
module pin_filter #(
  parameter int FILTER_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pin,
  input  logic [FILTER_W-1:0] filter,
  output logic                stable
);
  logic [1:0] sync;
  logic [FILTER_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= '0;
      cnt <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == stable) cnt <= '0;
      else if (cnt >= filter) begin
        stable <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + FILTER_W'(1);
    end
endmodule

// File: rtl/pin_capture.sv
// pin_capture: debounced pin level trigger with time latch (clk, rst async low, pins_in, clock_time, trigger_out, wb_* zero-wait slave)
module pin_capture
  import pin_capture_pkg::*;
#(
  parameter int NUM_PINS = 4,
  parameter int FILTER_W = 8,
  parameter int TS_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] pins_in,
  input  logic [TS_W-1:0]     clock_time,
  output logic                trigger_out,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o
);
  logic [FILTER_W-1:0] filter;
  logic [NUM_PINS-1:0] mask, level, stable, hit;
  logic triggered, wr, clr, match, unused_ok;
  logic [2:0] trig_pin;
  logic [TS_W-1:0] trig_time;
  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    pin_filter #(.FILTER_W(FILTER_W)) u_filter (
      .clk(clk), .rst(rst), .pin(pins_in[g]), .filter(filter), .stable(stable[g])
    );
  end
  assign wr = wb_cyc_i & wb_stb_i & wb_we_i;
  assign clr = wr && (wb_adr_i == ADDR_ARM || wb_adr_i == ADDR_STATUS);
  assign hit = mask & ~(stable ^ level);
  assign match = |hit;
  assign trigger_out = triggered;
  assign wb_ack_o = 1'b1;
  assign unused_ok = ^wb_dat_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      filter <= '0;
      mask <= '0;
      level <= '0;
      triggered <= 1'b0;
      trig_pin <= '0;
      trig_time <= '0;
    end else begin
      if (wr && wb_adr_i == ADDR_FILTER) filter <= wb_dat_i[FILTER_W-1:0];
      if (wr && wb_adr_i == ADDR_ARM) begin
        mask <= wb_dat_i[NUM_PINS-1:0];
        level <= wb_dat_i[ARM_LEVEL_LSB+:NUM_PINS];
      end
      if (clr) triggered <= 1'b0;
      else if (match && !triggered) begin
        triggered <= 1'b1;
        trig_pin <= lowest_set(8'(hit));
        trig_time <= clock_time;
      end
    end
  always_comb
    case (wb_adr_i)
      ADDR_FILTER: wb_dat_o = 32'(filter);
      ADDR_ARM:    wb_dat_o = (32'(level) << ARM_LEVEL_LSB) | 32'(mask);
      ADDR_STATUS: wb_dat_o = (32'(triggered) << STATUS_TRIG_BIT) | 32'(trig_pin);
      ADDR_TTIME:  wb_dat_o = 32'(trig_time);
      ADDR_STATE:  wb_dat_o = 32'(stable);
      default:     wb_dat_o = '0;
    endcase
endmodule

// File: tb/tb_pin_capture.sv
// tb_pin_capture: scoreboard bench for pin_capture debounce, trigger latch, clear race and async reset
module tb_pin_capture;
  import pin_capture_pkg::*;
  typedef struct {string n; logic [31:0] v;} exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] pins_in = '0;
  logic [31:0] clock_time;
  logic trigger_out, wb_stb_i = 0, wb_cyc_i = 0, wb_we_i = 0, wb_ack_o;
  logic [3:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0, wb_dat_o;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [31:0] d;
  pin_capture dut (
    .clk(clk), .rst(rst), .pins_in(pins_in), .clock_time(clock_time), .trigger_out(trigger_out),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign clock_time = 32'(1000 + cyc);
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    wb_adr_i = a; wb_dat_i = v; wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
    tick();
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    wb_adr_i = a;
    #1 v = wb_dat_o;
  endtask
  task automatic test_reset();
    pins_in = 4'hF; rst = 0;
    tick(2);
    exp_q.push_back('{"rst_state", 32'h0});
    exp_q.push_back('{"rst_ack", 32'h1});
    rd(ADDR_STATE, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    e = exp_q.pop_front(); n_chk++; if (32'(wb_ack_o) !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, wb_ack_o, e.v); end
    rst = 1;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back('{$sformatf("sync_state_c%0d", i), i < 3 ? 32'h0 : 32'hF});
      exp_q.push_back('{$sformatf("sync_trig_c%0d", i), 32'h0});
      tick();
      rd(ADDR_STATE, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
      e = exp_q.pop_front(); n_chk++; if (32'(trigger_out) !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, trigger_out, e.v); end
    end
  endtask
  task automatic test_debounce();
    pins_in = 4'h0;
    tick(4);
    wr(ADDR_FILTER, 32'd3);
    exp_q.push_back('{"filter_rd", 32'd3});
    rd(ADDR_FILTER, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    pins_in = 4'h2;
    tick(2);
    pins_in = 4'h0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{$sformatf("glitch_c%0d", i), 32'h0});
      tick();
      rd(ADDR_STATE, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    end
    pins_in = 4'h2;
    exp_q.push_back('{"pulse5_early", 32'h0});
    exp_q.push_back('{"pulse5_taken", 32'h2});
    tick(5);
    pins_in = 4'h0;
    rd(ADDR_STATE, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    tick();
    rd(ADDR_STATE, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    exp_q.push_back('{"pulse5_release", 32'h0});
    tick(10);
    rd(ADDR_STATE, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
  endtask
  task automatic test_trigger();
    wr(ADDR_FILTER, 32'd0);
    wr(ADDR_ARM, 32'h0000_0404);
    exp_q.push_back('{"arm_rd", 32'h0000_0404});
    rd(ADDR_ARM, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    pins_in = 4'h4;
    for (int i = 1; i <= 3; i++) exp_q.push_back('{$sformatf("trig_wait_c%0d", i), 32'h0});
    exp_q.push_back('{"trig_out", 32'h1});
    exp_q.push_back('{"trig_status", 32'h8000_0002});
    exp_q.push_back('{"trig_ttime", clock_time + 32'd3});
    for (int i = 1; i <= 4; i++) begin
      tick();
      e = exp_q.pop_front(); n_chk++; if (32'(trigger_out) !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, trigger_out, e.v); end
    end
    rd(ADDR_STATUS, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    rd(ADDR_TTIME, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
  endtask
  task automatic test_priority();
    logic [31:0] t;
    pins_in = 4'h0;
    tick(4);
    wr(ADDR_ARM, 32'h0000_0A0A);
    exp_q.push_back('{"arm_clears", 32'h0});
    e = exp_q.pop_front(); n_chk++; if (32'(trigger_out) !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, trigger_out, e.v); end
    pins_in = 4'hA;
    t = clock_time + 32'd3;
    exp_q.push_back('{"prio_status", 32'h8000_0001});
    exp_q.push_back('{"prio_ttime", t});
    tick(4);
    rd(ADDR_STATUS, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    rd(ADDR_TTIME, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    pins_in = 4'hB;
    exp_q.push_back('{"hold_status", 32'h8000_0001});
    exp_q.push_back('{"hold_ttime", t});
    tick(6);
    rd(ADDR_STATUS, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    rd(ADDR_TTIME, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
  endtask
  task automatic test_clear_race();
    wr(ADDR_STATUS, 32'hDEAD_BEEF);
    exp_q.push_back('{"race_clear", 32'h0});
    exp_q.push_back('{"race_retrig", 32'h1});
    exp_q.push_back('{"race_ttime", clock_time});
    exp_q.push_back('{"race_status", 32'h8000_0001});
    e = exp_q.pop_front(); n_chk++; if (32'(trigger_out) !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, trigger_out, e.v); end
    tick();
    e = exp_q.pop_front(); n_chk++; if (32'(trigger_out) !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, trigger_out, e.v); end
    rd(ADDR_TTIME, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    rd(ADDR_STATUS, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
  endtask
  task automatic test_async_reset();
    wr(ADDR_FILTER, 32'd5);
    pins_in = 4'h0;
    tick(3);
    exp_q.push_back('{"arst_trig", 32'h0});
    exp_q.push_back('{"arst_state", 32'h0});
    exp_q.push_back('{"arst_arm", 32'h0});
    exp_q.push_back('{"arst_status", 32'h0});
    exp_q.push_back('{"arst_ttime", 32'h0});
    #1 rst = 0;
    #1;
    e = exp_q.pop_front(); n_chk++; if (32'(trigger_out) !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, trigger_out, e.v); end
    rd(ADDR_STATE, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    rd(ADDR_ARM, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    rd(ADDR_STATUS, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    rd(ADDR_TTIME, d); e = exp_q.pop_front(); n_chk++; if (d !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.n, d, e.v); end
    tick();
    rst = 1;
    tick();
  endtask
  initial begin
    test_reset();
    test_debounce();
    test_trigger();
    test_priority();
    test_clear_race();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
